// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUTRAM configuration loader.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int lut_depth(input int k);
        return 1 << k;
    endfunction

    // A single LUT still needs a one-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_cfg_addr_gen.sv
// Address / LUT-index counter for the configuration stream, with wrap and last-bit flag.
module lut_cfg_addr_gen
    import lut_cfg_pkg::*;
#(
    parameter int NUM_LUTS = 16,
    parameter int LUT_K    = 6,
    parameter int IDX_W    = idx_width(NUM_LUTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             step_i,
    output logic [LUT_K-1:0] addr_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);
    localparam int DEPTH = lut_depth(LUT_K);

    logic [LUT_K-1:0] addr_q, addr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             addr_wrap;

    assign addr_wrap = (addr_q == LUT_K'(DEPTH - 1));
    assign last_o    = addr_wrap && (idx_q == IDX_W'(NUM_LUTS - 1));
    assign addr_o    = addr_q;
    assign idx_o     = idx_q;

    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
        if (clear_i || (step_i && last_o)) begin
            addr_d = '0;
            idx_d  = '0;
        end else if (step_i) begin
            if (addr_wrap) begin
                addr_d = '0;
                idx_d  = idx_q + IDX_W'(1);
            end else begin
                addr_d = addr_q + LUT_K'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/lut_cfg_ctrl.sv
// Streams serial config bits into NUM_LUTS LUTRAMs, one registered write per accepted bit.
// Define LUT_CFG_PARITY_EN to add a CHECK state that verifies a trailing even-parity bit.
module lut_cfg_ctrl
    import lut_cfg_pkg::*;
#(
    parameter int NUM_LUTS = 16,
    parameter int LUT_K    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                cfg_valid,
    input  logic                cfg_data,
    output logic                cfg_ready,
    output logic [LUT_K-1:0]    lut_a,
    output logic                lut_d,
    output logic [NUM_LUTS-1:0] lut_we,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int IDX_W = idx_width(NUM_LUTS);

    state_e              state_q, state_d;
    logic                start_ok, start_acc, accept, load_accept, last_bit;
    logic [LUT_K-1:0]    addr;
    logic [IDX_W-1:0]    lut_idx;
    logic [LUT_K-1:0]    lut_a_q, lut_a_d;
    logic                lut_d_q, lut_d_d;
    logic [NUM_LUTS-1:0] lut_we_q, lut_we_d;

    assign start_ok    = start & ~abort;
    assign start_acc   = start_ok & ((state_q == IDLE) | (state_q == DONE));
    assign accept      = cfg_valid & cfg_ready;
    assign load_accept = accept & (state_q == LOAD);

    lut_cfg_addr_gen #(
        .NUM_LUTS (NUM_LUTS),
        .LUT_K    (LUT_K),
        .IDX_W    (IDX_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (start_acc),
        .step_i  (load_accept),
        .addr_o  (addr),
        .idx_o   (lut_idx),
        .last_o  (last_bit)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_ok) state_d = LOAD;
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (load_accept && last_bit) begin
`ifdef LUT_CFG_PARITY_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LUT_CFG_PARITY_EN
            CHECK: begin
                if (abort)       state_d = IDLE;
                else if (accept) state_d = DONE;
            end
`else
            CHECK: state_d = IDLE;
`endif
            DONE:  if (start_ok) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Ready drops in the abort cycle itself so no bit is taken while cancelling.
    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            LOAD: begin
                cfg_ready = ~abort;
                busy      = 1'b1;
            end
`ifdef LUT_CFG_PARITY_EN
            CHECK: begin
                cfg_ready = ~abort;
                busy      = 1'b1;
            end
`endif
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        lut_a_d = lut_a_q;
        lut_d_d = lut_d_q;
        if (load_accept) begin
            lut_a_d = addr;
            lut_d_d = cfg_data;
        end
        for (int i = 0; i < NUM_LUTS; i++) begin
            lut_we_d[i] = load_accept && (lut_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_a_q  <= '0;
            lut_d_q  <= 1'b0;
            lut_we_q <= '0;
        end else begin
            lut_a_q  <= lut_a_d;
            lut_d_q  <= lut_d_d;
            lut_we_q <= lut_we_d;
        end
    end

    assign lut_a  = lut_a_q;
    assign lut_d  = lut_d_q;
    assign lut_we = lut_we_q;

`ifdef LUT_CFG_PARITY_EN
    logic parity_q, parity_d, err_q, err_d, check_accept;

    assign check_accept = accept & (state_q == CHECK);

    always_comb begin
        parity_d = parity_q;
        err_d    = err_q;
        if (start_acc) begin
            parity_d = 1'b0;
            err_d    = 1'b0;
        end else begin
            if (load_accept)  parity_d = parity_q ^ cfg_data;
            if (check_accept) err_d    = parity_q ^ cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            parity_q <= parity_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// Directed bench for lut_cfg_ctrl with NUM_LUTS=2, LUT_K=6 (128 config bits per load).
module tb_lut_cfg_ctrl;
    localparam int NL    = 2;
    localparam int K     = 6;
    localparam int DEPTH = 64;
    localparam int TOTAL = NL * DEPTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_data = 1'b0;
    logic          cfg_ready;
    logic [K-1:0]  lut_a;
    logic          lut_d;
    logic [NL-1:0] lut_we;
    logic          busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lut_cfg_ctrl #(.NUM_LUTS(NL), .LUT_K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .lut_a     (lut_a),
        .lut_d     (lut_d),
        .lut_we    (lut_we),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [NL-1:0] we;
        logic [K-1:0]  a;
        logic          d;
    } wr_t;

    wr_t wq[$];

    always @(negedge clk) begin
        if (rst_n && lut_we != '0) wq.push_back('{we: lut_we, a: lut_a, d: lut_d});
    end

    typedef struct {
        string        name;
        bit           stall;
        int           abort_after;
        int           exp_writes;
        logic         exp_done;
        logic         exp_busy;
        logic [K-1:0] exp_last_a;
        logic [NL-1:0] exp_last_we;
    } vec_t;

    function automatic logic pat(int i);
        return (i % 3) == 0;
    endfunction

    function automatic logic pat_xor();
        logic x = 1'b0;
        for (int i = 0; i < TOTAL; i++) x = x ^ pat(i);
        return x;
    endfunction

    function automatic wr_t exp_wr(int k);
        wr_t w;
        w.we = NL'(1) << (k / DEPTH);
        w.a  = K'(k % DEPTH);
        w.d  = pat(k);
        return w;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_writes(string name, int n_exp);
        int bad = 0;
        check({name, "_count"}, wq.size(), n_exp);
        for (int k = 0; k < wq.size() && k < n_exp; k++) begin
            if (wq[k] !== exp_wr(k)) bad++;
        end
        check({name, "_content"}, bad, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic feed_bit(int i);
        cfg_valid = 1'b1;
        cfg_data  = pat(i);
        @(negedge clk);
    endtask

    task automatic pulse_abort();
        abort = 1'b1; cfg_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        wq.delete();
        pulse_start();
        for (int i = 0; i < TOTAL; i++) begin
            if (v.abort_after >= 0 && i == v.abort_after) break;
            if (v.stall) begin
                cfg_valid = 1'b0;
                @(negedge clk);
            end
            feed_bit(i);
        end
        if (v.abort_after >= 0) begin
            pulse_abort();
        end else begin
`ifdef LUT_CFG_PARITY_EN
            cfg_valid = 1'b1;
            cfg_data  = pat_xor();
            @(negedge clk);
`endif
            cfg_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        #1;
        check_writes(v.name, v.exp_writes);
        check({v.name, "_done"}, done, v.exp_done);
        check({v.name, "_busy"}, busy, v.exp_busy);
        check({v.name, "_err"}, err, 1'b0);
        check({v.name, "_lut_a"}, lut_a, v.exp_last_a);
        check({v.name, "_last_we"}, (wq.size() > 0) ? wq[wq.size()-1].we : '0, v.exp_last_we);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"stream",   1'b0, -1, 128, 1'b1, 1'b0, 6'd63, 2'b10};
        vecs[1] = '{"stall",    1'b1, -1, 128, 1'b1, 1'b0, 6'd63, 2'b10};
        vecs[2] = '{"abort70",  1'b0, 70,  70, 1'b0, 1'b0, 6'd5,  2'b10};
        vecs[3] = '{"restart",  1'b0, -1, 128, 1'b1, 1'b0, 6'd63, 2'b10};

        // Reset state
        #12;
        check("reset_outputs", {cfg_ready, lut_a, lut_d, lut_we, busy, done, err}, '0);
        @(negedge clk); rst_n = 1'b1;

        // Start and abort together in IDLE: abort wins
        wq.delete();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) feed_bit(i);
        cfg_valid = 1'b0;
        #1;
        check("start_abort_busy", busy, 1'b0);
        check("start_abort_ready", cfg_ready, 1'b0);
        check("start_abort_writes", wq.size(), 0);

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Start during LOAD is ignored and counters keep going
        wq.delete();
        pulse_start();
        #1;
        check("restart_clears_done", done, 1'b0);
        for (int i = 0; i < 10; i++) feed_bit(i);
        start = 1'b1;
        feed_bit(10);
        start = 1'b0;
        #1;
        check("start_in_load_busy", busy, 1'b1);
        for (int i = 11; i < 20; i++) feed_bit(i);
        pulse_abort();
        repeat (3) @(negedge clk);
        #1;
        check_writes("start_in_load", 20);
        check("start_in_load_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a load
        pulse_start();
        for (int i = 0; i < 40; i++) feed_bit(i);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {cfg_ready, lut_a, lut_d, lut_we, busy, done, err}, '0);
        wq.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 40; i < 45; i++) feed_bit(i);
        cfg_valid = 1'b0;
        #1;
        check("post_reset_writes", wq.size(), 0);
        check("post_reset_busy", busy, 1'b0);

`ifdef LUT_CFG_PARITY_EN
        // Wrong parity bit sets a sticky err, cleared by the next start
        wq.delete();
        pulse_start();
        for (int i = 0; i < TOTAL; i++) feed_bit(i);
        cfg_valid = 1'b1;
        cfg_data  = ~pat_xor();
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_writes("bad_parity", 128);
        check("bad_parity_err", err, 1'b1);
        check("bad_parity_done", done, 1'b1);
        pulse_start();
        #1;
        check("restart_clears_err", err, 1'b0);
        check("restart_busy", busy, 1'b1);
        pulse_abort();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lut_cfg_ctrl.md
LUT_CFG_CTRL -- requirements
Module: lut_cfg_ctrl

Interface
REQ-001 SHALL have parameter NUM_LUTS, default 16, number of LUTRAM instances configured.
REQ-002 SHALL have parameter LUT_K, default 6, LUT input count; depth = 2**LUT_K.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a configuration load.
REQ-006 SHALL have port abort  input  1  single-cycle request to cancel a load.
REQ-007 SHALL have port cfg_valid  input  1  config bit available.
REQ-008 SHALL have port cfg_data  input  1  config bit value.
REQ-009 SHALL have port cfg_ready  output  1  controller accepts cfg_data this cycle.
REQ-010 SHALL have port lut_a  output  LUT_K  write address to all LUTRAMs.
REQ-011 SHALL have port lut_d  output  1  write data to all LUTRAMs.
REQ-012 SHALL have port lut_we  output  NUM_LUTS  one-hot write enable, bit i to LUT i.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  last load completed.
REQ-015 SHALL have port err  output  1  parity mismatch on last load.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, DONE.
REQ-017 IDLE: start -> LOAD, clearing done, err, address and LUT index; abort in the same cycle wins and the state stays IDLE.
REQ-018 LOAD: cfg_ready=1; a bit is accepted when cfg_valid && cfg_ready.
REQ-019 Each accepted bit SHALL produce exactly one write, registered one cycle later: lut_a=current address, lut_d=bit, lut_we=one-hot(current LUT index).
REQ-020 lut_we SHALL be all-zero in any cycle without a write; never more than one bit set.
REQ-021 Address SHALL increment 0..2**LUT_K-1 and then wrap to 0 while the LUT index increments.
REQ-022 Acceptance of bit (NUM_LUTS*2**LUT_K)-1 SHALL transition to CHECK if enabled, else to DONE.
REQ-023 cfg_valid low SHALL stall with no write and no counter change; there is no timeout.
REQ-024 abort in LOAD or CHECK -> IDLE next cycle, cfg_ready=0, no further writes, done=0, err=0; an already-registered write completes.
REQ-025 DONE: done=1, busy=0, cfg_ready=0; done and err stay sticky until the next accepted start; start -> LOAD.
REQ-026 busy=1 exactly in LOAD and CHECK; start in those states is ignored.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counters 0, cfg_ready=0, lut_a=0, lut_d=0, lut_we=0, busy=0, done=0, err=0.
REQ-028 Reset mid-load SHALL abandon the load; no write follows reset deassertion without a new start.

Configuration
REQ-029 Macro LUT_CFG_PARITY_EN SHALL enable the CHECK state.
REQ-030 With it defined: a running XOR over all accepted bits; CHECK accepts one extra bit (even parity) without a write; err=1 if extra bit != running XOR; then DONE.
REQ-031 Without it: no CHECK state, LOAD -> DONE directly, err tied to 0.

Structure
REQ-032 Package lut_cfg_pkg SHALL hold the state enum type and the LUT depth constant function/localparam.
REQ-033 Sub-module lut_cfg_addr_gen SHALL hold the address/LUT-index counter with wrap and last-bit flag.

Verification (NUM_LUTS=2, LUT_K=6, 128 bits)
REQ-034 Reset, start, 128 bits streamed back-to-back -> 64 writes with lut_we=2'b01 (a=0..63), then 64 with 2'b10, then done=1, busy=0.
REQ-035 cfg_valid toggled every other cycle -> same 128 writes, no write during stall cycles, final lut_a=63.
REQ-036 abort after 70 accepted bits -> IDLE, writes stop after bit 70, done=0; new start restarts at lut_a=0 with lut_we=2'b01.
REQ-037 Start and abort in the same IDLE cycle -> stays IDLE, busy=0, no writes; start during LOAD -> ignored, counters unchanged.
REQ-038 LUT_CFG_PARITY_EN, pattern with XOR=1, parity bit 1 -> done=1, err=0; parity bit 0 -> err=1; no write for the parity bit.
REQ-039 rst_n asserted asynchronously mid-load at bit 40 -> all outputs 0 immediately; after release, no writes until start.
